// File: rtl/axi_pmu_pkg.sv
// Shared response codes, FSM state types and field widths for the
// AXI-Lite to multi-bank PMU counter bridge.
package axi_pmu_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned BANK_FIELD_W = 4;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

endpackage

// File: rtl/pmu_sync_arn.sv
// Multi-flop synchroniser for one bank acknowledge bit; async active-low reset.
module pmu_sync_arn #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/axi_pmu_bridge_mc.sv
// AXI4-Lite slave bridging host accesses to NUM_BANKS PMU counter banks,
// each driven through a 4-phase enable/acknowledge handshake.
module axi_pmu_bridge_mc
  import axi_pmu_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH    = 64,
  parameter int unsigned C_S_AXI_ADDR_WIDTH    = 64,
  parameter int unsigned COUNTER_ADDRESS_WIDTH = 16,
  parameter int unsigned COUNTER_DATA_WIDTH    = 64,
  parameter int unsigned NUM_BANKS             = 4,
  parameter int unsigned BANK_SEL_LSB          = 16,
  parameter int unsigned TIMEOUT_CYCLES        = 256,
  parameter int unsigned SYNC_STAGES           = 2
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [NUM_BANKS-1:0]                     counter_read_enable,
  input  logic [NUM_BANKS-1:0]                     counter_read_valid,
  output logic [COUNTER_ADDRESS_WIDTH-1:0]         counter_read_address,
  input  logic [NUM_BANKS*COUNTER_DATA_WIDTH-1:0]  counter_read_data,
  output logic [NUM_BANKS-1:0]                     counter_write_enable,
  input  logic [NUM_BANKS-1:0]                     counter_write_valid,
  output logic [COUNTER_ADDRESS_WIDTH-1:0]         counter_write_address,
  output logic [COUNTER_DATA_WIDTH-1:0]            counter_write_data,
  output logic [COUNTER_DATA_WIDTH/8-1:0]          counter_write_strobe,
  output logic [15:0]                              timeout_count
);

  localparam int unsigned DW    = COUNTER_DATA_WIDTH;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_BANKS-1:0] sync_wv, sync_rv;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_sync
    pmu_sync_arn #(.STAGES(SYNC_STAGES)) u_wv (
      .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .d(counter_write_valid[b]), .q(sync_wv[b]));
    pmu_sync_arn #(.STAGES(SYNC_STAGES)) u_rv (
      .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .d(counter_read_valid[b]), .q(sync_rv[b]));
  end

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  logic                    aw_held, w_held, ar_held;
  logic [BANK_FIELD_W-1:0] aw_bank, ar_bank;
  logic                    w_release, r_release, w_to, r_to;

  // Address/data beat capture; each READY is a one-cycle pulse while nothing is held.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0; aw_held <= 1'b0; aw_bank <= '0; counter_write_address <= '0;
      S_AXI_WREADY  <= 1'b0; w_held  <= 1'b0; counter_write_data <= '0; counter_write_strobe <= '0;
      S_AXI_ARREADY <= 1'b0; ar_held <= 1'b0; ar_bank <= '0; counter_read_address <= '0;
    end else begin
      S_AXI_AWREADY <= !aw_held && !S_AXI_AWREADY && S_AXI_AWVALID;
      S_AXI_WREADY  <= !w_held  && !S_AXI_WREADY  && S_AXI_WVALID;
      S_AXI_ARREADY <= !ar_held && !S_AXI_ARREADY && S_AXI_ARVALID;
      if (S_AXI_AWREADY && S_AXI_AWVALID) begin
        aw_held               <= 1'b1;
        aw_bank               <= S_AXI_AWADDR[BANK_SEL_LSB +: BANK_FIELD_W];
        counter_write_address <= S_AXI_AWADDR[COUNTER_ADDRESS_WIDTH-1:0];
      end else if (w_release) aw_held <= 1'b0;
      if (S_AXI_WREADY && S_AXI_WVALID) begin
        w_held               <= 1'b1;
        counter_write_data   <= S_AXI_WDATA;
        counter_write_strobe <= S_AXI_WSTRB;
      end else if (w_release) w_held <= 1'b0;
      if (S_AXI_ARREADY && S_AXI_ARVALID) begin
        ar_held              <= 1'b1;
        ar_bank              <= S_AXI_ARADDR[BANK_SEL_LSB +: BANK_FIELD_W];
        counter_read_address <= S_AXI_ARADDR[COUNTER_ADDRESS_WIDTH-1:0];
      end else if (r_release) ar_held <= 1'b0;
    end
  end

  logic [NUM_BANKS-1:0] wsel, rsel;
  logic                 wack, rack;
  logic [DW-1:0]        rd_slice;

  // One-hot bank decode; an out-of-range bank field decodes to all zeros.
  always_comb begin
    wsel     = '0;
    rsel     = '0;
    rd_slice = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      wsel[b] = (aw_bank == BANK_FIELD_W'(b));
      rsel[b] = (ar_bank == BANK_FIELD_W'(b));
      if (rsel[b]) rd_slice = counter_read_data[b*DW +: DW];
    end
  end

  assign wack = |(sync_wv & wsel);
  assign rack = |(sync_rv & rsel);

  wr_state_t            w_state, w_state_nxt;
  rd_state_t            r_state, r_state_nxt;
  logic [TMR_W-1:0]     w_timer, w_timer_nxt, r_timer, r_timer_nxt;
  logic [NUM_BANKS-1:0] wen_nxt, ren_nxt;
  logic                 bvalid_nxt, rvalid_nxt, b_done, b_done_nxt, r_done, r_done_nxt;
  logic [1:0]           bresp_nxt, rresp_nxt;
  logic [DW-1:0]        rdata_nxt;

  // Write FSM next state and registered-output values.
  always_comb begin
    w_state_nxt = w_state;
    w_timer_nxt = w_timer;
    wen_nxt     = counter_write_enable;
    bvalid_nxt  = S_AXI_BVALID;
    bresp_nxt   = S_AXI_BRESP;
    b_done_nxt  = b_done;
    w_release   = 1'b0;
    w_to        = 1'b0;
    case (w_state)
      W_IDLE: if (aw_held && w_held) begin
        if (|wsel) begin
          wen_nxt     = wsel;
          w_timer_nxt = '0;
          w_state_nxt = W_REQ;
        end else begin
          bresp_nxt   = RESP_DECERR;
          bvalid_nxt  = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_REQ: begin
        w_timer_nxt = w_timer + TMR_W'(1);
        if (wack) begin
          wen_nxt = '0; bresp_nxt = RESP_OKAY; bvalid_nxt = 1'b1; w_state_nxt = W_RESP;
        end else if (w_timer == TMR_LAST) begin
          wen_nxt = '0; bresp_nxt = RESP_SLVERR; bvalid_nxt = 1'b1; w_state_nxt = W_RESP;
          w_to = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
          bvalid_nxt = 1'b0;
          b_done_nxt = 1'b1;
        end
        if ((b_done || (S_AXI_BVALID && S_AXI_BREADY)) && !wack) begin
          b_done_nxt  = 1'b0;
          w_release   = 1'b1;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read FSM mirrors the write FSM; RDATA is captured with RVALID and cleared on handshake.
  always_comb begin
    r_state_nxt = r_state;
    r_timer_nxt = r_timer;
    ren_nxt     = counter_read_enable;
    rvalid_nxt  = S_AXI_RVALID;
    rresp_nxt   = S_AXI_RRESP;
    rdata_nxt   = S_AXI_RDATA;
    r_done_nxt  = r_done;
    r_release   = 1'b0;
    r_to        = 1'b0;
    case (r_state)
      R_IDLE: if (ar_held) begin
        if (|rsel) begin
          ren_nxt     = rsel;
          r_timer_nxt = '0;
          r_state_nxt = R_REQ;
        end else begin
          rresp_nxt = RESP_DECERR; rdata_nxt = '0; rvalid_nxt = 1'b1; r_state_nxt = R_RESP;
        end
      end
      R_REQ: begin
        r_timer_nxt = r_timer + TMR_W'(1);
        if (rack) begin
          ren_nxt = '0; rresp_nxt = RESP_OKAY; rdata_nxt = rd_slice; rvalid_nxt = 1'b1;
          r_state_nxt = R_RESP;
        end else if (r_timer == TMR_LAST) begin
          ren_nxt = '0; rresp_nxt = RESP_SLVERR; rdata_nxt = '0; rvalid_nxt = 1'b1;
          r_state_nxt = R_RESP;
          r_to = 1'b1;
        end
      end
      R_RESP: begin
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          rvalid_nxt = 1'b0;
          rdata_nxt  = '0;
          r_done_nxt = 1'b1;
        end
        if ((r_done || (S_AXI_RVALID && S_AXI_RREADY)) && !rack) begin
          r_done_nxt  = 1'b0;
          r_release   = 1'b1;
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  logic [16:0] to_sum;
  assign to_sum = 17'(timeout_count) + 17'(w_to) + 17'(r_to);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state <= W_IDLE; w_timer <= '0; counter_write_enable <= '0;
      S_AXI_BVALID <= 1'b0; S_AXI_BRESP <= 2'b00; b_done <= 1'b0;
      r_state <= R_IDLE; r_timer <= '0; counter_read_enable <= '0;
      S_AXI_RVALID <= 1'b0; S_AXI_RRESP <= 2'b00; S_AXI_RDATA <= '0; r_done <= 1'b0;
      timeout_count <= '0;
    end else begin
      w_state <= w_state_nxt; w_timer <= w_timer_nxt; counter_write_enable <= wen_nxt;
      S_AXI_BVALID <= bvalid_nxt; S_AXI_BRESP <= bresp_nxt; b_done <= b_done_nxt;
      r_state <= r_state_nxt; r_timer <= r_timer_nxt; counter_read_enable <= ren_nxt;
      S_AXI_RVALID <= rvalid_nxt; S_AXI_RRESP <= rresp_nxt; S_AXI_RDATA <= rdata_nxt;
      r_done <= r_done_nxt;
      timeout_count <= to_sum[16] ? 16'hFFFF : to_sum[15:0];
    end
  end

endmodule

// File: tb/tb_axi_pmu_bridge_mc.sv
// Directed bench for axi_pmu_bridge_mc: decode, handshakes, error responses,
// timeout and asynchronous reset.
module tb_axi_pmu_bridge_mc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  awaddr, wdata, araddr, rdata;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [7:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [3:0]   ren, crv, wen, cwv;
  logic [15:0]  raddr, waddr, tcount;
  logic [255:0] crd;
  logic [63:0]  cwdata;
  logic [7:0]   cwstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_pmu_bridge_mc #(.TIMEOUT_CYCLES(16)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .counter_read_enable(ren), .counter_read_valid(crv), .counter_read_address(raddr),
    .counter_read_data(crd), .counter_write_enable(wen), .counter_write_valid(cwv),
    .counter_write_address(waddr), .counter_write_data(cwdata), .counter_write_strobe(cwstrb),
    .timeout_count(tcount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [63:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < 20) begin tick(); n++; end
    check("awready_wait", awready, 1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < 20) begin tick(); n++; end
    check("wready_wait", wready, 1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [63:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    check("arready_wait", arready, 1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_b(input int max);
    int n = 0;
    while (!bvalid && n < max) begin tick(); n++; end
    check("bvalid_wait", bvalid, 1);
  endtask

  task automatic wait_r(input int max);
    int n = 0;
    while (!rvalid && n < max) begin tick(); n++; end
    check("rvalid_wait", rvalid, 1);
  endtask

  task automatic wait_wen(input int max);
    int n = 0;
    while (wen == 4'b0 && n < max) begin tick(); n++; end
    check("wen_wait", (wen != 4'b0), 1);
  endtask

  // Complete write whose bank acknowledges as soon as it is enabled.
  task automatic full_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            input logic [1:0] exp, input string tag);
    bready = 1'b1;
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_wen(10);
    cwv = wen;
    wait_b(20);
    check({tag, "_bresp"}, bresp, exp);
    tick();
    check({tag, "_bdone"}, bvalid, 0);
    cwv = '0;
    repeat (4) tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    crv = '0; cwv = '0; crd = '0;
    repeat (3) tick();
    check("rst_wen", wen, 0);
    check("rst_ren", ren, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_awready", awready, 0);
    check("rst_tcount", tcount, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Plain write to bank 2, acknowledged a few cycles after enable.
    bready = 1'b1;
    fork
      send_aw(64'h0000_0000_0002_0010);
      send_w(64'hDEAD_BEEF_0000_0001, 8'hFF);
    join
    tick();
    check("t1_wen", wen, 4'b0100);
    check("t1_waddr", waddr, 16'h0010);
    check("t1_wdata", cwdata, 64'hDEAD_BEEF_0000_0001);
    check("t1_wstrb", cwstrb, 8'hFF);
    check("t1_bvalid_early", bvalid, 0);
    repeat (4) tick();
    cwv[2] = 1'b1;
    wait_b(20);
    check("t1_wen_drop", wen, 0);
    check("t1_bresp", bresp, 2'b00);
    tick();
    check("t1_single_b", bvalid, 0);
    cwv = '0;
    repeat (4) tick();

    // Read from bank 1 with the write channels idle.
    crd[64 +: 64] = 64'h1234;
    crd[0 +: 64]  = 64'hFFFF_0000;
    rready = 1'b1;
    send_ar(64'h0000_0000_0001_0008);
    tick();
    check("t2_ren", ren, 4'b0010);
    check("t2_raddr", raddr, 16'h0008);
    check("t2_wen_idle", wen, 0);
    crv[1] = 1'b1;
    wait_r(20);
    check("t2_rdata", rdata, 64'h1234);
    check("t2_rresp", rresp, 2'b00);
    check("t2_ren_drop", ren, 0);
    tick();
    check("t2_rvalid_clr", rvalid, 0);
    check("t2_rdata_clr", rdata, 0);
    crv = '0;
    repeat (4) tick();

    // Out-of-range bank field decodes to DECERR on both paths.
    fork
      send_aw(64'h0000_0000_0007_0000);
      send_w(64'h55, 8'h01);
    join
    wait_b(10);
    check("t3_wen", wen, 0);
    check("t3_bresp", bresp, 2'b11);
    repeat (3) tick();
    crd[64 +: 64] = 64'hAAAA;
    send_ar(64'h0000_0000_0007_0000);
    wait_r(10);
    check("t3_ren", ren, 0);
    check("t3_rresp", rresp, 2'b11);
    check("t3_rdata", rdata, 0);
    repeat (3) tick();

    // Bank 3 never acknowledges: SLVERR after 16 enabled cycles.
    fork
      send_aw(64'h0000_0000_0003_0020);
      send_w(64'h77, 8'hF0);
    join
    tick();
    check("t4_wen", wen, 4'b1000);
    n = 1;
    while (n < 40) begin
      tick();
      if (wen == 4'b1000) n++;
      else break;
    end
    check("t4_en_cycles", n, 16);
    check("t4_bvalid", bvalid, 1);
    check("t4_bresp", bresp, 2'b10);
    check("t4_tcount", tcount, 1);
    cwv[3] = 1'b1;
    repeat (5) tick();
    check("t4_late_bvalid", bvalid, 0);
    check("t4_late_wen", wen, 0);
    cwv = '0;
    repeat (4) tick();
    full_write(64'h0000_0000_0000_0004, 64'h99, 8'h0F, 2'b00, "t4_next");
    check("t4_tcount_hold", tcount, 1);

    // Back-pressured B channel keeps its response and blocks a new address.
    bready = 1'b0;
    fork
      send_aw(64'h0000_0000_0001_0000);
      send_w(64'h11, 8'h03);
    join
    wait_wen(10);
    cwv = wen;
    wait_b(20);
    awaddr = 64'h0000_0000_0002_0000;
    awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_bvalid", bvalid, 1);
      check("t5_bresp", bresp, 2'b00);
      check("t5_awready", awready, 0);
    end
    awvalid = 1'b0;
    bready = 1'b1;
    tick();
    check("t5_bdone", bvalid, 0);
    cwv = '0;
    repeat (4) tick();

    // Asynchronous reset while a write is waiting for its acknowledge.
    fork
      send_aw(64'h0000_0000_0002_0040);
      send_w(64'h42, 8'hFF);
    join
    tick();
    check("t6_wen", wen, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wen", wen, 0);
    check("t6_rst_ren", ren, 0);
    check("t6_rst_bvalid", bvalid, 0);
    check("t6_rst_rvalid", rvalid, 0);
    check("t6_rst_tcount", tcount, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    full_write(64'h0000_0000_0002_0040, 64'h43, 8'hFF, 2'b00, "t6_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
